// File: rtl/uart_stim_gen.sv
// UART frame generator with a byte FIFO front end: configurable frame format,
// baud divisor, FIFO depth and inter-frame idle gap, one registered TXD line.
module uart_stim_gen #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned GAP_BITS     = 0
) (
  input  logic                          CLK50M,
  input  logic                          n_RST,
  input  logic                          WR_EN,
  input  logic [7:0]                    WR_DATA,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          FRAME_DONE
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam bit          HAS_PAR = (PARITY != 0);
  localparam bit          ODD_PAR = (PARITY == 1);
  localparam logic [7:0]  DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]         mem [FIFO_DEPTH];

  logic               bit_end_c;
  logic               frame_end_c;
  logic               pop_c;
  logic               wr_ok_c;
  logic [7:0]         load_data_c;
  logic               load_par_c;
  logic [LEVEL_W-1:0] level_d;
  logic               txd_d;
  logic               busy_d;
  logic               done_d;

  assign wr_ok_c     = WR_EN && !FULL;
  assign bit_end_c   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign load_data_c = mem[rd_ptr_q] & DATA_MASK;
  assign load_par_c  = (^load_data_c) ^ ODD_PAR;

  // FIFO storage; pointers are cleared by reset, contents need not be
  always_ff @(posedge CLK50M) begin
    if (wr_ok_c) begin
      mem[wr_ptr_q] <= WR_DATA;
    end
  end

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pop_c       = 1'b0;
    frame_end_c = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!EMPTY) begin
          pop_c = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (GAP_BITS != 0) begin
              state_d = S_GAP;
            end else begin
              frame_end_c = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(GAP_BITS - 1)) begin
            bit_d       = '0;
            frame_end_c = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Back-to-back frames: the next start bit follows the last idle cycle directly
    if (frame_end_c) begin
      if (EMPTY) begin
        state_d = S_IDLE;
      end else begin
        pop_c = 1'b1;
      end
    end

    if (pop_c) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = load_data_c;
      par_d   = load_par_c;
    end
  end

  // Outputs are decoded from next state so the registered copies line up with it
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) &&
             (cnt_d == CNT_W'(CLKS_PER_BIT - 1)) &&
             (bit_d == BIT_W'(STOP_BITS - 1));
  end

  // Occupancy bookkeeping; a simultaneous write and pop cancel out
  always_comb begin
    level_d = LEVEL;
    unique case ({wr_ok_c, pop_c})
      2'b10:   level_d = LEVEL + LEVEL_W'(1);
      2'b01:   level_d = LEVEL - LEVEL_W'(1);
      default: level_d = LEVEL;
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (!n_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      LEVEL      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      TXD        <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(wr_ok_c);
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop_c);
      LEVEL      <= level_d;
      FULL       <= (level_d == LEVEL_W'(FIFO_DEPTH));
      EMPTY      <= (level_d == '0);
      TXD        <= txd_d;
      BUSY       <= busy_d;
      FRAME_DONE <= done_d;
    end
  end

endmodule
